display_scheduler: RTL and testbench

- Decides which source owns the shared 4-digit seven-segment display.
- Sources in priority order: timed message (highest), item price, running balance (background).
- Emits four registered BCD/code nibbles plus a blank control. These drive the display driver's digit inputs and its clear input.
- Sits between the vending FSM and the display driver.

---
 rtl/display_scheduler.sv | 178 +++++++++++++++++
 tb/tb_display_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler
//
// Arbitrates ownership of the shared 4-digit seven-segment display between
// three sources, highest priority first: timed message, item price and the
// running balance (background). The selected 16-bit value is split into four
// registered nibbles for the display driver. blank feeds the driver's clear.
//
// Optional feature macro: BLINK_EN
//   When defined, blank toggles every BLINK_HALF cycles while a message is
//   shown. When undefined, blank is high only during reset.
//
// Ports:
//   clk         system clock, rising edge
//   clr         synchronous active-high reset
//   bal_bcd     balance, 4 BCD digits
//   price_req   level, price should be shown
//   price_bcd   price, 4 BCD digits, sampled live while PRICE is active
//   msg_req     single-cycle message request pulse
//   msg_code    four glyph codes, captured when msg_req is high
//   dig1..dig4  registered digits, dig1 leftmost
//   blank       registered, high = display dark
//   active_src  registered, 00 BAL / 01 PRICE / 10 MSG
//   msg_busy    registered, high while in MSG
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned MSG_CYCLES  = 100_000_000,
    parameter int unsigned BLINK_HALF  = 25_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] bal_bcd,
    input  logic        price_req,
    input  logic [15:0] price_bcd,
    input  logic        msg_req,
    input  logic [15:0] msg_code,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [3:0]  dig4,
    output logic        blank,
    output logic [1:0]  active_src,
    output logic        msg_busy
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned MW = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [MW-1:0] MSG_MAX  = MW'(MSG_CYCLES - 1);

    // Encodings double as the active_src code.
    typedef enum logic [1:0] {
        StBal   = 2'b00,
        StPrice = 2'b01,
        StMsg   = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [MW-1:0]  msg_tmr_q, msg_tmr_d;
    logic [15:0]    latch_q, latch_d;
    logic [15:0]    sel_d;
    logic           blank_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBal: begin
                if (msg_req)        state_d = StMsg;
                else if (price_req) state_d = StPrice;
            end
            StPrice: begin
                // A message preempts even before the hold time has elapsed.
                if (msg_req)                                state_d = StMsg;
                else if ((hold_q == HOLD_MAX) && !price_req) state_d = StBal;
            end
            StMsg: begin
                // A fresh request at the expiry edge keeps the message up.
                if (!msg_req && (msg_tmr_q == MSG_MAX))
                    state_d = price_req ? StPrice : StBal;
            end
            default: state_d = StBal;
        endcase
    end

    // Hold timer sits at zero outside PRICE, so every entry starts from zero.
    always_comb begin
        hold_d = '0;
        if (state_q == StPrice)
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end

    always_comb begin
        msg_tmr_d = '0;
        latch_d   = latch_q;
        if (msg_req) begin
            latch_d   = msg_code;
            msg_tmr_d = '0;
        end else if (state_q == StMsg) begin
            msg_tmr_d = (msg_tmr_q == MSG_MAX) ? msg_tmr_q : msg_tmr_q + 1'b1;
        end
    end

    always_comb begin
        sel_d = bal_bcd;
        unique case (state_d)
            StBal:   sel_d = bal_bcd;
            StPrice: sel_d = price_bcd;
            StMsg:   sel_d = latch_d;
            default: sel_d = bal_bcd;
        endcase
    end

`ifdef BLINK_EN
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // MSG is only ever entered on msg_req, so restarting on msg_req or when
    // outside MSG covers every entry as well as every repeat request.
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (!msg_req && (state_q == StMsg)) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
        blank_d = (state_d == StMsg) ? phase_d : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign blank_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StBal;
            hold_q     <= '0;
            msg_tmr_q  <= '0;
            latch_q    <= '0;
            dig1       <= 4'h0;
            dig2       <= 4'h0;
            dig3       <= 4'h0;
            dig4       <= 4'h0;
            blank      <= 1'b1;
            active_src <= 2'b00;
            msg_busy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            msg_tmr_q  <= msg_tmr_d;
            latch_q    <= latch_d;
            dig1       <= sel_d[15:12];
            dig2       <= sel_d[11:8];
            dig3       <= sel_d[7:4];
            dig4       <= sel_d[3:0];
            blank      <= blank_d;
            active_src <= state_d;
            msg_busy   <= (state_d == StMsg);
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with HOLD_CYCLES=4, MSG_CYCLES=8,
// BLINK_HALF=2. Expected output words are queued as stimulus is applied and
// compared after the following clock edge.
module tb_display_scheduler;

    localparam int unsigned H = 4;
    localparam int unsigned M = 8;
    localparam int unsigned B = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] bal_bcd;
    logic        price_req;
    logic [15:0] price_bcd;
    logic        msg_req;
    logic [15:0] msg_code;
    logic [3:0]  dig1, dig2, dig3, dig4;
    logic        blank;
    logic [1:0]  active_src;
    logic        msg_busy;

    logic [22:0] obs;
    logic [22:0] got, want;
    logic [22:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign obs = {dig1, dig2, dig3, dig4, blank, active_src, msg_busy};

    always #5 clk = ~clk;

    display_scheduler #(
        .HOLD_CYCLES(H),
        .MSG_CYCLES (M),
        .BLINK_HALF (B)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .bal_bcd   (bal_bcd),
        .price_req (price_req),
        .price_bcd (price_bcd),
        .msg_req   (msg_req),
        .msg_code  (msg_code),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3),
        .dig4      (dig4),
        .blank     (blank),
        .active_src(active_src),
        .msg_busy  (msg_busy)
    );

    // Expected word: digits, blank, source, busy (busy is high exactly in MSG).
    function automatic logic [22:0] mk(input logic [15:0] d, input logic b,
                                       input logic [1:0] s);
        return {d, b, s, (s == 2'b10)};
    endfunction

    // Blank during the k-th cycle (1-based) since the last message (re)start.
    function automatic logic msg_blank(input int k);
`ifdef BLINK_EN
        return (((k - 1) / int'(B)) % 2) == 1;
`else
        return (k < 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bal_bcd   = 16'h0125;
        price_bcd = 16'h0000;
        msg_code  = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            clr       = (i < 2);
            price_req = (i < 2);
            msg_req   = (i < 2);
            exp_q.push_back((i < 2) ? mk(16'h0000, 1'b1, 2'b00) : mk(16'h0125, 1'b0, 2'b00));
            tick();
            got  = obs;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_price_hold();
        price_bcd = 16'h0050;
        msg_req   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            price_req = (i == 0);
            exp_q.push_back((i < 4) ? mk(16'h0050, 1'b0, 2'b01) : mk(16'h0125, 1'b0, 2'b00));
            tick();
            got  = obs;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL price_hold[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    // Message preempts PRICE on its 2nd cycle; PRICE returns with a fresh hold.
    task automatic test_msg_preempt();
        price_bcd = 16'h0050;
        for (int i = 0; i < 15; i++) begin
            price_req = (i <= 10);
            msg_req   = (i == 2);
            msg_code  = (i == 2) ? 16'hABCD : 16'hEEEE;
            if (i < 2 || (i >= 10 && i <= 13))
                exp_q.push_back(mk(16'h0050, 1'b0, 2'b01));
            else if (i < 10)
                exp_q.push_back(mk(16'hABCD, msg_blank(i - 1), 2'b10));
            else
                exp_q.push_back(mk(16'h0125, 1'b0, 2'b00));
            tick();
            got  = obs;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL msg_preempt[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    // Repeat request on cycle 5, then another exactly at the expiry edge.
    task automatic test_msg_restart();
        price_req = 1'b0;
        for (int i = 0; i < 22; i++) begin
            msg_req  = (i == 0 || i == 5 || i == 13);
            msg_code = (i == 0) ? 16'h5678 : (i == 5) ? 16'h1111 :
                       (i == 13) ? 16'h2222 : 16'hEEEE;
            if (i < 5)
                exp_q.push_back(mk(16'h5678, msg_blank(i + 1), 2'b10));
            else if (i < 13)
                exp_q.push_back(mk(16'h1111, msg_blank(i - 4), 2'b10));
            else if (i < 21)
                exp_q.push_back(mk(16'h2222, msg_blank(i - 12), 2'b10));
            else
                exp_q.push_back(mk(16'h0125, 1'b0, 2'b00));
            tick();
            got  = obs;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL msg_restart[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    // Simultaneous requests in BAL: MSG first, then PRICE with a live value.
    task automatic test_simultaneous();
        price_bcd = 16'h0075;
        for (int i = 0; i < 13; i++) begin
            price_req = (i <= 8);
            msg_req   = (i == 0);
            msg_code  = (i == 0) ? 16'h0F0F : 16'hEEEE;
            if (i < 8)
                exp_q.push_back(mk(16'h0F0F, msg_blank(i + 1), 2'b10));
            else if (i < 12)
                exp_q.push_back(mk(16'h0075, 1'b0, 2'b01));
            else
                exp_q.push_back(mk(16'h0125, 1'b0, 2'b00));
            tick();
            got  = obs;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous[%0d]: got %h required %h", i, got, want);
            end
        end
    endtask

    // Reset on the 3rd message cycle aborts it; nothing resumes afterwards.
    task automatic test_reset_mid_msg();
        price_req = 1'b0;
        for (int i = 0; i < 13; i++) begin
            clr      = (i == 3);
            msg_req  = (i == 0 || i == 3);
            msg_code = (i == 0) ? 16'h9999 : 16'h4444;
            if (i < 3)
                exp_q.push_back(mk(16'h9999, msg_blank(i + 1), 2'b10));
            else if (i == 3)
                exp_q.push_back(mk(16'h0000, 1'b1, 2'b00));
            else
                exp_q.push_back(mk(16'h0125, 1'b0, 2'b00));
            tick();
            got  = obs;
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_msg[%0d]: got %h required %h", i, got, want);
            end
        end
        clr     = 1'b0;
        msg_req = 1'b0;
    endtask

    initial begin
        clr       = 1'b1;
        price_req = 1'b0;
        msg_req   = 1'b0;
        msg_code  = 16'h0000;
        bal_bcd   = 16'h0125;
        price_bcd = 16'h0000;
        test_reset();
        test_price_hold();
        test_msg_preempt();
        test_msg_restart();
        test_simultaneous();
        test_reset_mid_msg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
